// File: rtl/fir_capture.sv
// Response-capture buffer for the FIR output stream.
// Captures DEPTH samples, tracks signed peaks, replays over valid/ready.
module fir_capture #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int SKIP   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] y_in,
   output logic              cap_busy,
   output logic              cap_done,
   output logic [DATA_W-1:0] peak_max,
   output logic [DATA_W-1:0] peak_min,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SKIP,
      S_CAPTURE,
      S_PREFETCH,
      S_READOUT
   } state_t;

   localparam logic [DATA_W-1:0] MOST_NEG =
      {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MOST_POS =
      {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [7:0]        SKIP_LAST = 8'(SKIP - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [7:0]        skip_cnt_q;
   logic              cap_busy_q;
   logic              cap_done_q;
   logic              rd_valid_q;
   logic              rd_last_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] peak_max_q;
   logic [DATA_W-1:0] peak_min_q;
   logic [DATA_W-1:0] mem [DEPTH];

   // Buffer write port, used only while capturing
   always_ff @(posedge clk) begin
      if (state_q == S_CAPTURE) begin
         mem[wr_ptr_q] <= y_in;
      end
   end

   // Capture/readout sequencer; rd_data_q is the read-ahead register
   always_ff @(posedge clk) begin
      cap_done_q <= 1'b0;
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         skip_cnt_q <= '0;
         cap_busy_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
         peak_max_q <= MOST_NEG;
         peak_min_q <= MOST_POS;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  peak_max_q <= MOST_NEG;
                  peak_min_q <= MOST_POS;
                  skip_cnt_q <= '0;
                  wr_ptr_q   <= '0;
                  cap_busy_q <= 1'b1;
                  state_q    <= (SKIP > 0) ? S_SKIP : S_CAPTURE;
               end
            end
            S_SKIP: begin
               skip_cnt_q <= skip_cnt_q + 8'd1;
               if (skip_cnt_q == SKIP_LAST) begin
                  state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if ($signed(y_in) > $signed(peak_max_q)) begin
                  peak_max_q <= y_in;
               end
               if ($signed(y_in) < $signed(peak_min_q)) begin
                  peak_min_q <= y_in;
               end
               wr_ptr_q <= wr_ptr_q + 1'b1;
               if (wr_ptr_q == LAST_ADDR) begin
                  cap_busy_q <= 1'b0;
                  state_q    <= S_PREFETCH;
               end
            end
            S_PREFETCH: begin
               rd_data_q  <= mem['0];
               rd_ptr_q   <= ADDR_W'(1);
               rd_valid_q <= 1'b1;
               rd_last_q  <= 1'b0;
               state_q    <= S_READOUT;
            end
            S_READOUT: begin
               if (rd_ready) begin
                  if (rd_last_q) begin
                     rd_valid_q <= 1'b0;
                     rd_last_q  <= 1'b0;
                     cap_done_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     rd_data_q <= mem[rd_ptr_q];
                     rd_ptr_q  <= rd_ptr_q + 1'b1;
                     rd_last_q <= (rd_ptr_q == LAST_ADDR);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cap_busy = cap_busy_q;
   assign cap_done = cap_done_q;
   assign peak_max = peak_max_q;
   assign peak_min = peak_min_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_fir_capture.sv
// Bench for fir_capture: scoreboard queue filled by stimulus,
// drained by a negedge monitor on the read port.
module tb_fir_capture;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0;
   logic        start3;
   logic [31:0] y_in;
   logic        rd_ready;

   logic        busy0, done0, valid0, last0;
   logic        busy3, done3, valid3, last3;
   logic [31:0] pmax0, pmin0, data0;
   logic [31:0] pmax3, pmin3, data3;

   int sel = 0;
   int rdy_mode = 0;
   int tests = 0;
   int fails = 0;
   int xfer = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   logic [31:0] expq [$];

   logic        m_valid, m_last, m_busy, m_done;
   logic [31:0] m_data, m_pmax, m_pmin;

   always #5 clk = ~clk;

   fir_capture #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(8), .SKIP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .y_in(y_in),
      .cap_busy(busy0), .cap_done(done0),
      .peak_max(pmax0), .peak_min(pmin0),
      .rd_valid(valid0), .rd_ready(rd_ready),
      .rd_data(data0), .rd_last(last0)
   );

   fir_capture #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(8), .SKIP(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .y_in(y_in),
      .cap_busy(busy3), .cap_done(done3),
      .peak_max(pmax3), .peak_min(pmin3),
      .rd_valid(valid3), .rd_ready(rd_ready),
      .rd_data(data3), .rd_last(last3)
   );

   assign m_valid = (sel == 1) ? valid3 : valid0;
   assign m_last  = (sel == 1) ? last3  : last0;
   assign m_busy  = (sel == 1) ? busy3  : busy0;
   assign m_done  = (sel == 1) ? done3  : done0;
   assign m_data  = (sel == 1) ? data3  : data0;
   assign m_pmax  = (sel == 1) ? pmax3  : pmax0;
   assign m_pmin  = (sel == 1) ? pmin3  : pmin0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sample(input int mode, input int k);
      case (mode)
         0: return 32'(k);
         1: return 32'(100 + k);
         2: return (k == 10) ? 32'hFFFF_FFFB :
                   ((k == 20) ? 32'h7FFF_FFFF : 32'h0);
         default: return (k < 8) ? 32'h0 : 32'h4000;
      endcase
   endfunction

   // rd_ready pattern: always 1, or repeating 1,0,0
   initial begin
      int cyc;
      cyc = 0;
      rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rd_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
         cyc++;
      end
   end

   // Monitor: pops expected samples on each transfer, checks stalls
   initial begin
      bit          stall_pend;
      logic [31:0] stall_data;
      logic        stall_last;
      logic [31:0] e;
      stall_pend = 1'b0;
      stall_data = '0;
      stall_last = 1'b0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            stall_pend = 1'b0;
         end else begin
            if (m_done === 1'b1) done_cnt++;
            if (m_busy === 1'b1) busy_cnt++;
            if (stall_pend) begin
               check("stall_valid", {31'b0, m_valid}, 32'd1);
               check("stall_data", m_data, stall_data);
               check("stall_last", {31'b0, m_last}, {31'b0, stall_last});
            end
            stall_pend = 1'b0;
            if (m_valid === 1'b1 && rd_ready) begin
               if (expq.size() == 0) begin
                  check("extra_xfer", m_data, 32'hDEAD_BEEF);
               end else begin
                  e = expq.pop_front();
                  check($sformatf("rd_data[%0d]", xfer), m_data, e);
                  check($sformatf("rd_last[%0d]", xfer),
                        {31'b0, m_last},
                        (xfer == DEPTH - 1) ? 32'd1 : 32'd0);
               end
               xfer++;
            end else if (m_valid === 1'b1) begin
               stall_pend = 1'b1;
               stall_data = m_data;
               stall_last = m_last;
            end
         end
      end
   end

   task automatic burst(input int s, input int mode, input int skip,
                        input logic [31:0] emax, input logic [31:0] emin,
                        input int pulse_k, input int abort_at);
      int  d0;
      bit  to;
      sel = s;
      xfer = 0;
      busy_cnt = 0;
      d0 = done_cnt;
      expq.delete();
      for (int i = 0; i < DEPTH; i++) expq.push_back(sample(mode, i + skip));
      tick();
      if (s == 1) start3 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0;
      start3 = 1'b0;
      y_in = sample(mode, 0);
      for (int k = 1; k <= DEPTH + skip; k++) begin
         tick();
         y_in = sample(mode, k);
         if (s == 1) start3 = (k == pulse_k); else start0 = (k == pulse_k);
      end
      start0 = 1'b0;
      start3 = 1'b0;
      to = 1'b1;
      if (abort_at >= 0) begin
         for (int c = 0; c < 3000; c++) begin
            if (xfer >= abort_at) begin
               to = 1'b0;
               break;
            end
            tick();
         end
         check("abort_wait_timeout", {31'b0, to}, 32'd0);
         rst = 1'b1;
         tick();
         check("abort_rd_valid", {31'b0, m_valid}, 32'd0);
         check("abort_cap_busy", {31'b0, m_busy}, 32'd0);
         check("abort_cap_done", {31'b0, m_done}, 32'd0);
         rst = 1'b0;
         expq.delete();
         for (int c = 0; c < 5; c++) tick();
         check("abort_no_done", 32'(done_cnt), 32'(d0));
         check("abort_no_valid", {31'b0, m_valid}, 32'd0);
      end else begin
         for (int c = 0; c < 3000; c++) begin
            if (done_cnt != d0) begin
               to = 1'b0;
               break;
            end
            tick();
         end
         check("done_timeout", {31'b0, to}, 32'd0);
         check("xfer_count", 32'(xfer), 32'(DEPTH));
         check("queue_left", 32'(expq.size()), 32'd0);
         check("peak_max", m_pmax, emax);
         check("peak_min", m_pmin, emin);
         check("busy_cycles", 32'(busy_cnt), 32'(skip + DEPTH));
         for (int c = 0; c < 3; c++) tick();
         check("done_pulses", 32'(done_cnt), 32'(d0 + 1));
         check("peak_hold_max", m_pmax, emax);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start0 = 1'b0;
      start3 = 1'b0;
      y_in = '0;
      tick();
      tick();
      start0 = 1'b1;
      start3 = 1'b1;
      tick();
      rst = 1'b0;
      start0 = 1'b0;
      start3 = 1'b0;
      tick();
      check("rst_busy0", {31'b0, busy0}, 32'd0);
      check("rst_busy3", {31'b0, busy3}, 32'd0);
      check("rst_done0", {31'b0, done0}, 32'd0);
      check("rst_valid0", {31'b0, valid0}, 32'd0);
      check("rst_valid3", {31'b0, valid3}, 32'd0);
      check("rst_last0", {31'b0, last0}, 32'd0);
      check("rst_data0", data0, 32'h0);
      check("rst_pmax0", pmax0, 32'h8000_0000);
      check("rst_pmin0", pmin0, 32'h7FFF_FFFF);
      check("rst_pmax3", pmax3, 32'h8000_0000);
      check("rst_pmin3", pmin3, 32'h7FFF_FFFF);

      rdy_mode = 0;
      burst(0, 0, 0, 32'd255, 32'd0, 100, -1);
      burst(1, 1, 3, 32'd358, 32'd103, -1, -1);
      rdy_mode = 1;
      burst(0, 0, 0, 32'd255, 32'd0, -1, -1);
      rdy_mode = 0;
      burst(0, 2, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFB, -1, -1);
      burst(0, 0, 0, 32'd0, 32'd0, 50, 50);
      burst(0, 3, 0, 32'h4000, 32'h0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
